// File: rtl/tcb_lite_sram_sub.sv
// TCB-lite subordinate with an internal byte-enabled synchronous RAM, fixed response delay of one cycle.
// Optional random stall injection is compiled in with the TCB_SRAM_STALL_EN macro.
module tcb_lite_sram_sub #(
  parameter logic [31:0] MEM_ADR = 32'h8000_0000,
  parameter int unsigned MEM_SIZ = 2**22,
  parameter string       MFN     = "",
  parameter logic [15:0] STL_SED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tcb_vld,
  input  logic        tcb_wen,
  input  logic [31:0] tcb_adr,
  input  logic [1:0]  tcb_siz,
  input  logic [31:0] tcb_wdt,
  output logic [31:0] tcb_rdt,
  output logic        tcb_err,
  output logic        tcb_rdy
);

  localparam int unsigned AW    = $clog2(MEM_SIZ);
  localparam int unsigned DEPTH = MEM_SIZ / 4;

  function automatic logic [3:0] byte_en(input logic [1:0] siz, input logic [1:0] off);
    logic [3:0] be;
    case (siz)
      2'd0:    be = 4'b0001 << off;
      2'd1:    be = 4'b0011 << off;
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic aligned(input logic [1:0] siz, input logic [1:0] off);
    logic ok;
    case (siz)
      2'd0:    ok = 1'b1;
      2'd1:    ok = ~off[0];
      2'd2:    ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] rd_extract(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] siz);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (siz)
      2'd0:    res = {24'h00_0000, sh[7:0]};
      2'd1:    res = {16'h0000, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  logic [31:0]   mem [0:DEPTH-1];
  logic          xfer;
  logic [AW-3:0] idx;
  logic [1:0]    off;
  logic          rng;
  logic          aln;
  logic          err_req;
  logic          wr_ok;
  logic          rd_ok;
  logic [3:0]    be;
  logic [31:0]   wdat;
  logic [31:0]   rd_word;
  logic          rsp_rd;
  logic          rsp_err;
  logic [1:0]    rsp_off;
  logic [1:0]    rsp_siz;

`ifdef TCB_SRAM_STALL_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= STL_SED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end

  assign tcb_rdy = ~rst & (lfsr[1:0] != 2'b00);
`else
  logic [15:0] unused_sed;

  assign unused_sed = STL_SED;
  assign tcb_rdy    = ~rst;
`endif

  assign xfer    = tcb_vld & tcb_rdy;
  assign idx     = tcb_adr[AW-1:2];
  assign off     = tcb_adr[1:0];
  assign rng     = (tcb_adr[31:AW] == MEM_ADR[31:AW]);
  assign aln     = aligned(tcb_siz, off);
  assign err_req = ~rng | ~aln;
  assign wr_ok   = xfer & tcb_wen & ~err_req;
  assign rd_ok   = xfer & ~tcb_wen & ~err_req;
  assign be      = byte_en(tcb_siz, off);
  assign wdat    = tcb_wdt << {off, 3'b000};

  // Byte-lane write port; RAM contents survive reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_ok && be[b]) begin
        mem[idx][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
  end

  // Synchronous read port; holds its word until the next accepted read.
  always_ff @(posedge clk) begin
    if (rd_ok) begin
      rd_word <= mem[idx];
    end
  end

  // Response attributes update only on a transfer, so idle cycles hold the last response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rd  <= 1'b0;
      rsp_err <= 1'b0;
      rsp_off <= 2'b00;
      rsp_siz <= 2'b00;
    end else if (xfer) begin
      rsp_rd  <= ~tcb_wen & ~err_req;
      rsp_err <= err_req;
      rsp_off <= off;
      rsp_siz <= tcb_siz;
    end
  end

  // Writes and errored transfers answer with zero data.
  always_comb begin
    tcb_rdt = 32'h0000_0000;
    if (rsp_rd) begin
      tcb_rdt = rd_extract(rd_word, rsp_off, rsp_siz);
    end else begin
      tcb_rdt = 32'h0000_0000;
    end
  end

  assign tcb_err = rsp_err;

endmodule

// File: tb/tb_tcb_lite_sram_sub.sv
// Directed table-driven bench for tcb_lite_sram_sub plus hand sequences for reset, hold and reset mid-burst.
module tb_tcb_lite_sram_sub;

  logic        clk;
  logic        rst;
  logic        tcb_vld;
  logic        tcb_wen;
  logic [31:0] tcb_adr;
  logic [1:0]  tcb_siz;
  logic [31:0] tcb_wdt;
  logic [31:0] tcb_rdt;
  logic        tcb_err;
  logic        tcb_rdy;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic        wen;
    logic [31:0] adr;
    logic [1:0]  siz;
    logic [31:0] wdt;
    logic [31:0] exp_rdt;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t tbl[$];

  tcb_lite_sram_sub dut (
    .clk     (clk),
    .rst     (rst),
    .tcb_vld (tcb_vld),
    .tcb_wen (tcb_wen),
    .tcb_adr (tcb_adr),
    .tcb_siz (tcb_siz),
    .tcb_wdt (tcb_wdt),
    .tcb_rdt (tcb_rdt),
    .tcb_err (tcb_err),
    .tcb_rdy (tcb_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic add(input logic wen, input logic [31:0] adr, input logic [1:0] siz,
                     input logic [31:0] wdt, input logic [31:0] exp_rdt, input logic exp_err,
                     input string name);
    vec_t v;
    v.wen = wen; v.adr = adr; v.siz = siz; v.wdt = wdt;
    v.exp_rdt = exp_rdt; v.exp_err = exp_err; v.name = name;
    tbl.push_back(v);
  endtask

  // Drive one request and return #1 after the edge that accepted it (response visible).
  task automatic req(input logic wen, input logic [31:0] adr, input logic [1:0] siz,
                     input logic [31:0] wdt, input string nm);
    logic ok;
    ok = 1'b0;
    tcb_vld = 1'b1; tcb_wen = wen; tcb_adr = adr; tcb_siz = siz; tcb_wdt = wdt;
    for (int i = 0; i < 32; i++) begin
      if (tcb_rdy) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_timeout: rdy never seen, got 0 expected 1", nm);
    end
  endtask

  initial begin
    rst = 1'b1; tcb_vld = 1'b0; tcb_wen = 1'b0;
    tcb_adr = 32'h0000_0000; tcb_siz = 2'd0; tcb_wdt = 32'h0000_0000;

    add(1'b1, 32'h8000_0010, 2'd2, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, "wr_word");
    add(1'b0, 32'h8000_0010, 2'd2, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, "rd_word_after_wr");
    add(1'b1, 32'h8000_0013, 2'd0, 32'h0000_005A, 32'h0000_0000, 1'b0, "wr_byte3");
    add(1'b0, 32'h8000_0010, 2'd2, 32'h0000_0000, 32'h5AAD_BEEF, 1'b0, "rd_word_merged");
    add(1'b0, 32'h8000_0012, 2'd1, 32'h0000_0000, 32'h0000_5AAD, 1'b0, "rd_half_hi");
    add(1'b0, 32'h8000_0011, 2'd0, 32'h0000_0000, 32'h0000_00BE, 1'b0, "rd_byte1");
    add(1'b1, 32'h8000_0400, 2'd2, 32'h1234_5678, 32'h0000_0000, 1'b0, "wr_word_400");
    add(1'b0, 32'h8000_0011, 2'd1, 32'h0000_0000, 32'h0000_0000, 1'b1, "rd_half_misaligned");
    add(1'b1, 32'h8000_0402, 2'd2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "wr_word_misaligned");
    add(1'b0, 32'h8000_0400, 2'd2, 32'h0000_0000, 32'h1234_5678, 1'b0, "rd_400_unchanged");
    add(1'b1, 32'h8000_0402, 2'd1, 32'hABCD_BEEF, 32'h0000_0000, 1'b0, "wr_half_hi");
    add(1'b0, 32'h8000_0400, 2'd2, 32'h0000_0000, 32'hBEEF_5678, 1'b0, "rd_400_half_merged");
    add(1'b1, 32'h8000_0000, 2'd2, 32'h1122_3344, 32'h0000_0000, 1'b0, "wr_word_0");
    add(1'b1, 32'h8040_0000, 2'd2, 32'hCAFE_F00D, 32'h0000_0000, 1'b1, "wr_out_of_window");
    add(1'b0, 32'h8000_0000, 2'd3, 32'h0000_0000, 32'h0000_0000, 1'b1, "rd_siz3");
    add(1'b0, 32'h8000_0000, 2'd2, 32'h0000_0000, 32'h1122_3344, 1'b0, "rd_0_unchanged");
    add(1'b1, 32'h8000_0001, 2'd0, 32'hFFFF_FF99, 32'h0000_0000, 1'b0, "wr_byte1");
    add(1'b0, 32'h8000_0000, 2'd2, 32'h0000_0000, 32'h1122_9944, 1'b0, "rd_0_byte_merged");
    add(1'b0, 32'h8000_0002, 2'd1, 32'h0000_0000, 32'h0000_1122, 1'b0, "rd_half_2");
    add(1'b0, 32'h8000_0003, 2'd0, 32'h0000_0000, 32'h0000_0011, 1'b0, "rd_byte_3");
    add(1'b0, 32'h7FFF_FFFC, 2'd2, 32'h0000_0000, 32'h0000_0000, 1'b1, "rd_below_window");
    add(1'b0, 32'h8000_0002, 2'd2, 32'h0000_0000, 32'h0000_0000, 1'b1, "rd_word_misaligned");
    add(1'b1, 32'h8000_0000, 2'd2, 32'h0000_0000, 32'h0000_0000, 1'b0, "pre_0");
    add(1'b1, 32'h8000_0004, 2'd2, 32'h0000_0001, 32'h0000_0000, 1'b0, "pre_4");
    add(1'b1, 32'h8000_0008, 2'd2, 32'h0000_0002, 32'h0000_0000, 1'b0, "pre_8");
    add(1'b1, 32'h8000_000C, 2'd2, 32'h0000_0003, 32'h0000_0000, 1'b0, "pre_c");
    add(1'b0, 32'h8000_0000, 2'd2, 32'h0000_0000, 32'h0000_0000, 1'b0, "burst_0");
    add(1'b0, 32'h8000_0004, 2'd2, 32'h0000_0000, 32'h0000_0001, 1'b0, "burst_4");
    add(1'b0, 32'h8000_0008, 2'd2, 32'h0000_0000, 32'h0000_0002, 1'b0, "burst_8");
    add(1'b0, 32'h8000_000C, 2'd2, 32'h0000_0000, 32'h0000_0003, 1'b0, "burst_c");
    add(1'b1, 32'h803F_FFFC, 2'd2, 32'h89AB_CDEF, 32'h0000_0000, 1'b0, "wr_top_word");
    add(1'b0, 32'h803F_FFFC, 2'd2, 32'h0000_0000, 32'h89AB_CDEF, 1'b0, "rd_top_word");

    // Reset state, sampled every reset cycle.
    repeat (4) begin
      @(posedge clk); #1;
      check("rst_rdy", {31'b0, tcb_rdy}, 32'h0000_0000);
      check("rst_rdt", tcb_rdt, 32'h0000_0000);
      check("rst_err", {31'b0, tcb_err}, 32'h0000_0000);
    end
    rst = 1'b0;
    #1;
    check("rdy_after_rst", {31'b0, tcb_rdy}, 32'h0000_0001);

    // Back-to-back table application.
    foreach (tbl[i]) begin
      req(tbl[i].wen, tbl[i].adr, tbl[i].siz, tbl[i].wdt, tbl[i].name);
      check({tbl[i].name, "_rdt"}, tcb_rdt, tbl[i].exp_rdt);
      check({tbl[i].name, "_err"}, {31'b0, tcb_err}, {31'b0, tbl[i].exp_err});
    end

    // Idle cycles must hold the previous response.
    tcb_vld = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("hold_rdt", tcb_rdt, 32'h89AB_CDEF);
      check("hold_err", {31'b0, tcb_err}, 32'h0000_0000);
    end

    // Reset in the middle of a read burst.
    req(1'b0, 32'h8000_0004, 2'd2, 32'h0000_0000, "mid_rd_4");
    check("mid_rd_4_rdt", tcb_rdt, 32'h0000_0001);
    tcb_adr = 32'h8000_0008;
    rst = 1'b1;
    #1;
    check("mid_rst_rdy", {31'b0, tcb_rdy}, 32'h0000_0000);
    @(posedge clk); #1;
    check("mid_rst_rdt", tcb_rdt, 32'h0000_0000);
    check("mid_rst_err", {31'b0, tcb_err}, 32'h0000_0000);
    rst = 1'b0;
    req(1'b0, 32'h8000_0008, 2'd2, 32'h0000_0000, "post_rd_8");
    check("post_rd_8_rdt", tcb_rdt, 32'h0000_0002);
    req(1'b0, 32'h8000_000C, 2'd2, 32'h0000_0000, "post_rd_c");
    check("post_rd_c_rdt", tcb_rdt, 32'h0000_0003);
    req(1'b0, 32'h803F_FFFC, 2'd2, 32'h0000_0000, "post_rd_top");
    check("post_rd_top_rdt", tcb_rdt, 32'h89AB_CDEF);
    check("post_rd_top_err", {31'b0, tcb_err}, 32'h0000_0000);
    tcb_vld = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
